// File: rtl/shot_pkg.sv
// Shared definitions for the shot motion controller: FSM state encoding,
// register widths and screen geometry.
package shot_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_FLIGHT = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam int X_W    = 10;  // x position, unsigned
    localparam int Y_W    = 11;  // y position, signed
    localparam int VX_W   = 4;   // horizontal speed, unsigned
    localparam int VY_W   = 8;   // vertical speed, signed, positive = up
    localparam int VYIN_W = 5;   // launch speed input width
    localparam int CNT_W  = 8;   // frame counter (flight budget / result hold)

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/ball_step.sv
// Combinational one-frame ballistic step.
// Inputs : current x, y, vy, vx and frame counter.
// Outputs: next x/y/vy/counter plus hit (made shot) and miss flags.
// Miss is suppressed whenever hit is set on the same update.
module ball_step
    import shot_pkg::*;
#(
    parameter int FLOOR_Y    = 460,
    parameter int X_MAX      = SCREEN_W - 1,
    parameter int HOOP_X_MIN = 40,
    parameter int HOOP_X_MAX = 60,
    parameter int HOOP_Y     = 250,
    parameter int GRAVITY    = 1,
    parameter int FLIGHT_MAX = 255
) (
    input  logic        [X_W-1:0]   x,
    input  logic signed [Y_W-1:0]   y,
    input  logic signed [VY_W-1:0]  vy,
    input  logic        [VX_W-1:0]  vx,
    input  logic        [CNT_W-1:0] cnt,
    output logic        [X_W-1:0]   x_nxt,
    output logic signed [Y_W-1:0]   y_nxt,
    output logic signed [VY_W-1:0]  vy_nxt,
    output logic        [CNT_W-1:0] cnt_nxt,
    output logic                    hit,
    output logic                    miss
);

    logic        [X_W:0]  x_sum;
    logic                 x_over;
    logic signed [Y_W:0]  y_diff;
    logic        [Y_W-1:0] y_pos;   // y - vy clamped at 0, before floor clamp
    logic                 floor_hit;
    logic signed [VY_W:0] vy_diff;
    logic                 in_window;

    always_comb begin
        x_sum  = {1'b0, x} + (X_W+1)'(vx);
        x_over = x_sum > (X_W+1)'(X_MAX);
        x_nxt  = x_over ? X_W'(X_MAX) : x_sum[X_W-1:0];

        // Subtract at one extra bit so the sign of the result is exact.
        y_diff    = $signed({y[Y_W-1], y}) - $signed({{(Y_W+1-VY_W){vy[VY_W-1]}}, vy});
        y_pos     = y_diff[Y_W] ? '0 : y_diff[Y_W-1:0];
        floor_hit = y_pos >= Y_W'(FLOOR_Y);
        y_nxt     = floor_hit ? $signed(Y_W'(FLOOR_Y)) : $signed(y_pos);

        // Overflow out of 8 bits can only be downward: pin at -128.
        vy_diff = $signed({vy[VY_W-1], vy}) - $signed((VY_W+1)'(GRAVITY));
        vy_nxt  = (vy_diff[VY_W] != vy_diff[VY_W-1]) ? $signed({1'b1, {(VY_W-1){1'b0}}})
                                                       : vy_diff[VY_W-1:0];

        cnt_nxt = cnt + 1'b1;

        // Made shot: descending, crossing the rim line downward inside the rim.
        in_window = (x_nxt >= X_W'(HOOP_X_MIN)) && (x_nxt <= X_W'(HOOP_X_MAX));
        hit  = vy[VY_W-1] && (y < $signed(Y_W'(HOOP_Y))) &&
               (y_pos >= Y_W'(HOOP_Y)) && in_window;
        miss = !hit && (floor_hit || x_over || (cnt_nxt == CNT_W'(FLIGHT_MAX)));
    end

endmodule

// File: rtl/shot_ball_ctrl.sv
// Per-frame shot motion controller: IDLE -> ARMED -> FLIGHT -> RESULT -> IDLE.
// All coordinate updates happen on the clock edge after a sampled frame_tick.
// Ports: clk, reset_n (async low), frame_tick, shoot, vx_in, vy_in ->
//        ball_x, ball_y, busy, score/miss (1-cycle pulses), score_count.
module shot_ball_ctrl
    import shot_pkg::*;
#(
    parameter int X0          = 10,
    parameter int Y0          = 300,
    parameter int GRAVITY     = 1,
    parameter int FLOOR_Y     = 460,
    parameter int X_MAX       = SCREEN_W - 1,
    parameter int HOOP_X_MIN  = 40,
    parameter int HOOP_X_MAX  = 60,
    parameter int HOOP_Y      = 250,
    parameter int FLIGHT_MAX  = 255,
    parameter int RESULT_HOLD = 60
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_tick,
    input  logic              shoot,
    input  logic [VX_W-1:0]   vx_in,
    input  logic [VYIN_W-1:0] vy_in,
    output logic [9:0]        ball_x,
    output logic [9:0]        ball_y,
    output logic              busy,
    output logic              score,
    output logic              miss,
    output logic [7:0]        score_count
);

    state_t                 state, state_n;
    logic        [X_W-1:0]  x, x_n;
    logic signed [Y_W-1:0]  y, y_n;
    logic signed [VY_W-1:0] vy, vy_n;
    logic        [VX_W-1:0] vx, vx_n;
    logic        [CNT_W-1:0] cnt, cnt_n;
    logic                   score_n, miss_n;
    logic        [7:0]      score_count_n;

    logic        [X_W-1:0]  st_x;
    logic signed [Y_W-1:0]  st_y;
    logic signed [VY_W-1:0] st_vy;
    logic        [CNT_W-1:0] st_cnt;
    logic                   st_hit, st_miss;

    ball_step #(
        .FLOOR_Y    (FLOOR_Y),
        .X_MAX      (X_MAX),
        .HOOP_X_MIN (HOOP_X_MIN),
        .HOOP_X_MAX (HOOP_X_MAX),
        .HOOP_Y     (HOOP_Y),
        .GRAVITY    (GRAVITY),
        .FLIGHT_MAX (FLIGHT_MAX)
    ) u_step (
        .x       (x),
        .y       (y),
        .vy      (vy),
        .vx      (vx),
        .cnt     (cnt),
        .x_nxt   (st_x),
        .y_nxt   (st_y),
        .vy_nxt  (st_vy),
        .cnt_nxt (st_cnt),
        .hit     (st_hit),
        .miss    (st_miss)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            x           <= X_W'(X0);
            y           <= $signed(Y_W'(Y0));
            vy          <= '0;
            vx          <= '0;
            cnt         <= '0;
            score       <= 1'b0;
            miss        <= 1'b0;
            score_count <= '0;
        end else begin
            state       <= state_n;
            x           <= x_n;
            y           <= y_n;
            vy          <= vy_n;
            vx          <= vx_n;
            cnt         <= cnt_n;
            score       <= score_n;
            miss        <= miss_n;
            score_count <= score_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        x_n           = x;
        y_n           = y;
        vy_n          = vy;
        vx_n          = vx;
        cnt_n         = cnt;
        score_n       = 1'b0;
        miss_n        = 1'b0;
        score_count_n = score_count;

        unique case (state)
            // frame_tick is deliberately not looked at here, so a tick in the
            // same cycle as shoot is left for ARMED to wait past.
            S_IDLE: begin
                if (shoot) begin
                    vx_n    = vx_in;
                    vy_n    = $signed({{(VY_W-VYIN_W){1'b0}}, vy_in});
                    state_n = S_ARMED;
                end
            end
            S_ARMED: begin
                if (frame_tick) begin
                    cnt_n   = '0;
                    state_n = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (frame_tick) begin
                    x_n   = st_x;
                    y_n   = st_y;
                    vy_n  = st_vy;
                    cnt_n = st_cnt;
                    if (st_hit) begin
                        score_n       = 1'b1;
                        score_count_n = score_count + 1'b1;
                    end
                    miss_n = st_miss;
                    if (st_hit || st_miss) begin
                        cnt_n   = '0;   // reused as the result hold counter
                        state_n = S_RESULT;
                    end
                end
            end
            S_RESULT: begin
                if (frame_tick) begin
                    if (cnt == CNT_W'(RESULT_HOLD - 1)) begin
                        x_n     = X_W'(X0);
                        y_n     = $signed(Y_W'(Y0));
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign ball_x = x;
    assign ball_y = y[9:0];
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_shot_ball_ctrl.sv
// Directed bench for shot_ball_ctrl: rest/reset state, a made shot, a floor
// miss with result hold, shoot ignored when busy, shoot+tick collision and
// asynchronous reset mid-flight.
module tb_shot_ball_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       shoot = 1'b0;
    logic [3:0] vx_in = '0;
    logic [4:0] vy_in = '0;
    logic [9:0] ball_x, ball_y;
    logic       busy, score, miss;
    logic [7:0] score_count;

    int errors = 0;
    int checks = 0;

    shot_ball_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .frame_tick  (frame_tick),
        .shoot       (shoot),
        .vx_in       (vx_in),
        .vy_in       (vy_in),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .busy        (busy),
        .score       (score),
        .miss        (miss),
        .score_count (score_count)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One idle cycle, then a single-cycle frame_tick; returns at a negedge
    // right after the tick edge so pulses are visible.
    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_shoot(input int vx, input int vy);
        vx_in = 4'(vx);
        vy_in = 5'(vy);
        shoot = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, "_x"}, int'(ball_x), ex);
        chk({tag, "_y"}, int'(ball_y), ey);
    endtask

    initial begin
        // Reset state
        #50;
        chk_pos("rst", 10, 300);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(score_count), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_miss", int'(miss), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Ticks in IDLE do nothing
        ticks(3);
        chk_pos("idle", 10, 300);
        chk("idle_busy", int'(busy), 0);

        // Made shot: vx=3, vy=10
        pulse_shoot(3, 10);
        chk("armed_busy", int'(busy), 1);
        chk_pos("armed", 10, 300);
        tick();                       // ARMED -> FLIGHT, no motion
        chk_pos("launch", 10, 300);
        tick();
        chk_pos("t1", 13, 290);
        ticks(4);
        chk_pos("t5", 25, 260);
        pulse_shoot(7, 3);            // ignored in FLIGHT
        chk_pos("t5_shoot", 25, 260);
        ticks(5);
        chk_pos("t10", 40, 245);
        ticks(3);
        chk_pos("t13", 49, 248);
        chk("t13_score", int'(score), 0);
        tick();
        chk_pos("t14", 52, 251);
        chk("t14_score", int'(score), 1);
        chk("t14_miss", int'(miss), 0);
        chk("t14_count", int'(score_count), 1);
        @(negedge clk);
        chk("score_pulse_end", int'(score), 0);

        // RESULT hold: frozen for 59 ticks, shoot ignored
        tick();
        pulse_shoot(9, 31);
        ticks(58);
        chk_pos("hold59", 52, 251);
        chk("hold59_busy", int'(busy), 1);
        chk("hold59_count", int'(score_count), 1);
        tick();
        chk_pos("hold60", 10, 300);
        chk("hold60_busy", int'(busy), 0);

        // Floor miss: vx=0, vy=0
        pulse_shoot(0, 0);
        tick();
        chk_pos("drop_launch", 10, 300);
        ticks(18);
        chk_pos("drop_t18", 10, 453);
        chk("drop_t18_miss", int'(miss), 0);
        tick();
        chk_pos("drop_t19", 10, 460);
        chk("drop_t19_miss", int'(miss), 1);
        chk("drop_t19_score", int'(score), 0);
        chk("drop_t19_count", int'(score_count), 1);
        @(negedge clk);
        chk("miss_pulse_end", int'(miss), 0);
        ticks(59);
        chk_pos("drop_hold59", 10, 460);
        tick();
        chk_pos("drop_hold60", 10, 300);
        chk("drop_hold60_busy", int'(busy), 0);

        // shoot and frame_tick in the same IDLE cycle
        vx_in = 4'd3;
        vy_in = 5'd10;
        shoot = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        shoot = 1'b0;
        frame_tick = 1'b0;
        chk("coll_busy", int'(busy), 1);
        chk_pos("coll", 10, 300);
        tick();
        chk_pos("coll_launch", 10, 300);
        tick();
        chk_pos("coll_t1", 13, 290);
        ticks(4);
        chk_pos("coll_t5", 25, 260);

        // Asynchronous reset mid-flight
        #5 reset_n = 1'b0;
        #1;
        chk_pos("arst", 10, 300);
        chk("arst_busy", int'(busy), 0);
        chk("arst_count", int'(score_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        ticks(2);
        chk_pos("arst_idle", 10, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
